// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared stall levels, stall patterns, FSM states and zero word.
package stall_ctrl_pkg;

   localparam logic STOP = 1'b1;
   localparam logic NON_STOP = 1'b0;

   localparam logic [31:0] ZERO_WORD = 32'h0;

   // Stall patterns always stop a contiguous run of stages starting at PC.
   localparam logic [5:0] STALL_NONE = {6{NON_STOP}};
   localparam logic [5:0] STALL_ID = {{3{NON_STOP}}, {3{STOP}}};
   localparam logic [5:0] STALL_EX = {{2{NON_STOP}}, {4{STOP}}};

   typedef enum logic [1:0] {
      IDLE,
      EX_WAIT,
      FLUSH
   } state_t;

endpackage

// File: rtl/stall_ctrl_sat_counter32.sv
// sat_counter32: 32-bit saturating event counter with clear taking priority.
module sat_counter32
   import stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] cnt
);

   always_ff @(posedge clk)
      if (!rst || clr) cnt <= ZERO_WORD;
      else if (inc && cnt != '1) cnt <= cnt + 32'd1;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller with EX multi-cycle timeout and stall-cycle counter.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MAX_EX_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        ex_done,
   input  logic        flush_req,
   input  logic [31:0] flush_pc,
   input  logic        perf_clr,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        ex_timeout,
   output logic [31:0] perf_stall_cnt
);

   localparam logic [7:0] CNT_LAST = 8'(MAX_EX_CYCLES - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       timeout_n;

   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         ex_timeout <= 1'b0;
         new_pc <= ZERO_WORD;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         ex_timeout <= timeout_n;
         if (flush_req) new_pc <= flush_pc;
      end

   // A flush request pre-empts everything, including a pending EX timeout.
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      timeout_n = 1'b0;
      if (flush_req) begin
         state_n = FLUSH;
         cnt_n = '0;
      end else
         case (state)
            IDLE:
               if (stallreq_from_ex) begin
                  state_n = EX_WAIT;
                  cnt_n = '0;
               end
            EX_WAIT:
               if (ex_done) state_n = IDLE;
               else if (cnt == CNT_LAST) begin
                  state_n = IDLE;
                  timeout_n = 1'b1;
               end else cnt_n = cnt + 8'd1;
            default: state_n = IDLE;
         endcase
   end

   // On the ex_done cycle the EX result advances, so only an ID hazard can stall.
   always_comb
      stall = (!rst || state == FLUSH) ? STALL_NONE :
              (state == EX_WAIT && !ex_done) ? STALL_EX :
              (state == IDLE && stallreq_from_ex) ? STALL_EX :
              stallreq_from_id ? STALL_ID : STALL_NONE;

   always_comb flush = (state == FLUSH);

   sat_counter32 u_perf (
      .clk(clk),
      .rst(rst),
      .inc(stall[0]),
      .clr(perf_clr),
      .cnt(perf_stall_cnt)
   );

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench driving a default and a MAX_EX_CYCLES=4 instance in lockstep.
module tb_stall_ctrl;

   localparam logic [5:0] S0 = 6'b000000;
   localparam logic [5:0] SI = 6'b000111;
   localparam logic [5:0] SE = 6'b001111;

   logic        clk = 1'b0, rst = 1'b0;
   logic        id = 1'b0, ex = 1'b0, dn = 1'b0, fr = 1'b0, clr = 1'b0;
   logic [31:0] fpc = '0;
   logic [5:0]  stall, stall4;
   logic        flush, flush4, to, to4;
   logic [31:0] npc, npc4, perf, perf4;

   always #5 clk = ~clk;

   stall_ctrl dut (
      .clk(clk), .rst(rst), .stallreq_from_id(id), .stallreq_from_ex(ex), .ex_done(dn),
      .flush_req(fr), .flush_pc(fpc), .perf_clr(clr), .stall(stall), .flush(flush),
      .new_pc(npc), .ex_timeout(to), .perf_stall_cnt(perf)
   );

   stall_ctrl #(.MAX_EX_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .stallreq_from_id(id), .stallreq_from_ex(ex), .ex_done(dn),
      .flush_req(fr), .flush_pc(fpc), .perf_clr(clr), .stall(stall4), .flush(flush4),
      .new_pc(npc4), .ex_timeout(to4), .perf_stall_cnt(perf4)
   );

   typedef struct {
      string       tag;
      logic [5:0]  es, es4;
      logic        ef, et, et4;
      logic [31:0] pc, perf, perf4;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_chk = 0, n_pass = 0;
   logic [31:0] m_pc = '0, m_perf = '0, m_perf4 = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One cycle of stimulus; registered expectations come from the small pc/perf model.
   task automatic cyc(input string tag, input bit r, input bit i_id, input bit i_ex, input bit i_dn,
                      input bit i_fr, input logic [31:0] pc, input bit i_clr,
                      input logic [5:0] es, input logic [5:0] es4, input bit ef, input bit et,
                      input bit et4);
      @(negedge clk);
      rst = r; id = i_id; ex = i_ex; dn = i_dn; fr = i_fr; fpc = pc; clr = i_clr;
      sb.push_back('{tag, es, es4, ef, et, et4, m_pc, m_perf, m_perf4});
      if (!r) begin
         m_pc = '0; m_perf = '0; m_perf4 = '0;
      end else begin
         if (i_fr) m_pc = pc;
         m_perf = i_clr ? 32'h0 : m_perf + 32'(es[0]);
         m_perf4 = i_clr ? 32'h0 : m_perf4 + 32'(es4[0]);
      end
   endtask

   initial forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".stall"}, 32'(stall), 32'(e.es));
         check({e.tag, ".flush"}, 32'(flush), 32'(e.ef));
         check({e.tag, ".new_pc"}, npc, e.pc);
         check({e.tag, ".timeout"}, 32'(to), 32'(e.et));
         check({e.tag, ".perf"}, perf, e.perf);
         check({e.tag, ".stall4"}, 32'(stall4), 32'(e.es4));
         check({e.tag, ".flush4"}, 32'(flush4), 32'(e.ef));
         check({e.tag, ".new_pc4"}, npc4, e.pc);
         check({e.tag, ".timeout4"}, 32'(to4), 32'(e.et4));
         check({e.tag, ".perf4"}, perf4, e.perf4);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      cyc("rst_hold", 0, 1, 1, 0, 1, 32'h55, 0, S0, S0, 0, 0, 0);
      cyc("idle", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("id_req", 1, 1, 0, 0, 0, 0, 0, SI, SI, 0, 0, 0);
      cyc("id_after", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("dn_idle", 1, 0, 0, 1, 0, 0, 0, S0, S0, 0, 0, 0);
      // ex_done after 5 wait cycles; the short instance times out first
      cyc("ex_start", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      for (int i = 1; i <= 5; i++)
         cyc("ex_wait", 1, 0, 0, 0, 0, 0, 0, SE, (i < 5) ? SE : S0, 0, 0, i == 5);
      cyc("ex_done", 1, 0, 0, 1, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("ex_after", 1, 1, 0, 0, 0, 0, 0, SI, SI, 0, 0, 0);
      // default instance runs to its 64-cycle limit
      cyc("to_start", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      for (int i = 1; i <= 64; i++)
         cyc("to_wait", 1, 0, 0, 0, 0, 0, 0, SE, (i < 5) ? SE : S0, 0, 0, i == 5);
      cyc("to_pulse", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 1, 0);
      cyc("to_end", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      // flush lands on the short instance's timeout cycle
      cyc("fl_start", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      for (int i = 1; i <= 3; i++)
         cyc("fl_wait", 1, 0, 0, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      cyc("fl_req", 1, 0, 0, 0, 1, 32'h180, 0, SE, SE, 0, 0, 0);
      cyc("fl_flush", 1, 1, 0, 0, 0, 0, 0, S0, S0, 1, 0, 0);
      cyc("fl_after", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("bb_req1", 1, 0, 0, 0, 1, 32'h100, 0, S0, S0, 0, 0, 0);
      cyc("bb_req2", 1, 0, 0, 0, 1, 32'h200, 0, S0, S0, 1, 0, 0);
      cyc("bb_fl2", 1, 0, 1, 0, 0, 0, 0, S0, S0, 1, 0, 0);
      cyc("bb_after", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("clr", 1, 1, 0, 0, 0, 0, 1, SI, SI, 0, 0, 0);
      cyc("clr_after", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("id_again", 1, 1, 0, 0, 0, 0, 0, SI, SI, 0, 0, 0);
      cyc("id_again2", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("rf_req", 1, 0, 0, 0, 1, 32'habc, 0, S0, S0, 0, 0, 0);
      cyc("rf_rst", 0, 1, 1, 0, 0, 0, 0, S0, S0, 1, 0, 0);
      cyc("rf_after", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("re_start", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      cyc("re_wait", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      cyc("re_rst", 0, 0, 1, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      cyc("re_idle", 1, 0, 1, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      cyc("re_wait2", 1, 0, 0, 0, 0, 0, 0, SE, SE, 0, 0, 0);
      cyc("re_done", 1, 1, 0, 1, 0, 0, 0, SI, SI, 0, 0, 0);
      cyc("re_end", 1, 0, 0, 0, 0, 0, 0, S0, S0, 0, 0, 0);
      @(negedge clk);
      #6;
      check("drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MAX_EX_CYCLES, 64, EX multi-cycle timeout limit in cycles (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 resets).
REQ-004 SHALL have port stallreq_from_id  input  1  ID hazard request (load-use), level, this cycle.
REQ-005 SHALL have port stallreq_from_ex  input  1  EX multi-cycle op start request, level.
REQ-006 SHALL have port ex_done  input  1  EX multi-cycle unit result valid, one-cycle pulse.
REQ-007 SHALL have port flush_req  input  1  exception/redirect request, one-cycle pulse.
REQ-008 SHALL have port flush_pc  input  32  redirect target, valid with flush_req.
REQ-009 SHALL have port perf_clr  input  1  clear stall-cycle counter.
REQ-010 SHALL have port stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-011 SHALL have port flush  output  1  registered pipeline flush pulse.
REQ-012 SHALL have port new_pc  output  32  registered redirect PC, valid while flush==1.
REQ-013 SHALL have port ex_timeout  output  1  registered one-cycle pulse, EX op exceeded limit.
REQ-014 SHALL have port perf_stall_cnt  output  32  cycles with stall[0]==1, saturating.

Function
REQ-015 SHALL implement states IDLE, EX_WAIT, FLUSH, plus 8-bit wait counter cnt.
REQ-016 stall SHALL be combinational from state and same-cycle inputs (zero latency): FLUSH -> 6'b000000; EX_WAIT and ex_done==0 -> 6'b001111; else stallreq_from_ex==1 -> 6'b001111; else stallreq_from_id==1 -> 6'b000111; else 6'b000000.
REQ-017 stall[5:4] SHALL always be 0; stall pattern SHALL always be contiguous from bit0.
REQ-018 IDLE -> EX_WAIT when stallreq_from_ex==1 and flush_req==0; cnt <= 0.
REQ-019 EX_WAIT: ex_done==1 -> IDLE next cycle; during the ex_done cycle stall follows IDLE rules for stallreq_from_id only (EX result advances).
REQ-020 EX_WAIT: cnt increments each cycle without ex_done; when cnt==MAX_EX_CYCLES-1 and ex_done==0 -> IDLE and ex_timeout==1 next cycle.
REQ-021 ex_done while IDLE or FLUSH SHALL be ignored.
REQ-022 flush_req==1 in any state SHALL give state FLUSH, flush==1, new_pc==flush_pc on next cycle; priority over all other requests; aborts EX_WAIT, cnt <= 0, no ex_timeout.
REQ-023 FLUSH SHALL last one cycle then go IDLE, unless flush_req==1 again, which re-enters FLUSH with new flush_pc.
REQ-024 flush SHALL be 0 outside FLUSH; new_pc SHALL hold last value when flush==0.
REQ-025 perf_stall_cnt SHALL increment by 1 each cycle stall[0]==1, saturate at 32'hFFFFFFFF; perf_clr==1 sets 0 next cycle (clear wins over increment).

Reset
REQ-026 rst==0 at a clock edge SHALL set state IDLE, cnt 0, flush 0, new_pc 32'h0, ex_timeout 0, perf_stall_cnt 0, overriding all inputs including mid-EX_WAIT or mid-FLUSH.
REQ-027 During reset, stall SHALL be 6'b000000 regardless of request inputs.

Structure
REQ-028 Stop/NonStop levels, stall pattern constants (6'b000111, 6'b001111), state encodings and ZeroWord SHALL live in the shared define file.
REQ-029 Saturating perf counter SHALL be one sub-module, sat_counter32; rest flat.

Verification
REQ-030 stallreq_from_id=1 one cycle in IDLE -> stall=6'b000111 that cycle, 0 next; perf_stall_cnt +1.
REQ-031 stallreq_from_ex=1, ex_done after 5 cycles -> stall=6'b001111 for 6 cycles, 0 on ex_done cycle, state IDLE next.
REQ-032 MAX_EX_CYCLES=4, ex_done never -> ex_timeout pulse after 5th stalled cycle, IDLE, stall=0.
REQ-033 flush_req with flush_pc=32'h0000_0180 during EX_WAIT -> next cycle flush=1, new_pc=32'h0000_0180, stall=0, then IDLE; no ex_timeout.
REQ-034 Back-to-back flush_req (32'h100 then 32'h200) -> flush high two cycles, new_pc 32'h100 then 32'h200.
REQ-035 rst=0 mid-EX_WAIT with stallreq_from_ex=1 held -> stall=0, all outputs reset; after release, EX_WAIT re-entered next cycle.
